// File: rtl/oam_dma_controller.sv
// oam_dma_controller: OAM DMA bus master; copies BYTES_PER_XFER bytes from {src_hi,8'h00} to DEST_BASE.
// Optional macro OAM_DMA_HRAM_PASSTHRU_EN lets CPU HRAM accesses through during DMA, stalling the copy.
module oam_dma_controller #(
    parameter int          BYTES_PER_XFER = 160,
    parameter logic [15:0] DEST_BASE      = 16'hFE00,
    parameter int          RD_LATENCY     = 1,
    parameter int          START_DELAY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    output logic [7:0]  Do_cpu,
    input  logic        rd_cpu_n,
    input  logic        wr_cpu_n,
    output logic [15:0] A,
    output logic [7:0]  Do,
    input  logic [7:0]  Di,
    output logic        rd_n,
    output logic        wr_n,
    output logic        dma_active
);
    typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;
    localparam logic [8:0] LAST_IDX = 9'(BYTES_PER_XFER);
    localparam logic [2:0] DLY_LAST = 3'(START_DELAY > 0 ? START_DELAY - 1 : 0);
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
    localparam state_t START_STATE = START_DELAY > 0 ? DELAY : READ;
    state_t state, state_nx;
    logic [7:0] src_hi, src_hi_nx, idx, idx_nx, data_q, data_nx;
    logic [2:0] dly_cnt, dly_nx;
    logic [1:0] lat_cnt, lat_nx;
    logic reg_wr, reg_rd, owns, stall, bus_cpu;
    logic [8:0] idx_inc;
    assign reg_wr = !wr_cpu_n && A_cpu == 16'hFF46;
    assign reg_rd = !rd_cpu_n && A_cpu == 16'hFF46;
    assign owns = state == READ || state == WRITE;
`ifdef OAM_DMA_HRAM_PASSTHRU_EN
    assign stall = owns && (!rd_cpu_n || !wr_cpu_n) && A_cpu >= 16'hFF80 && A_cpu != 16'hFFFF;
`else
    assign stall = 1'b0;
`endif
    // the CPU owns the bus outside READ/WRITE, and for a stalled HRAM cycle
    assign bus_cpu = !owns || stall;
    assign idx_inc = {1'b0, idx} + 9'd1;
    assign dma_active = state != IDLE;
    assign A = bus_cpu ? A_cpu : state == READ ? {src_hi, idx} : DEST_BASE + {8'h00, idx};
    assign Do = bus_cpu ? Di_cpu : state == READ ? 8'hFF : data_q;
    assign rd_n = bus_cpu ? rd_cpu_n : state != READ;
    assign wr_n = bus_cpu ? wr_cpu_n : state != WRITE;
    assign Do_cpu = reg_rd ? src_hi : bus_cpu ? Di : 8'hFF;
    always_comb begin
        state_nx = state;
        src_hi_nx = src_hi;
        idx_nx = idx;
        data_nx = data_q;
        dly_nx = dly_cnt;
        lat_nx = lat_cnt;
        if (reg_wr) begin
            src_hi_nx = Di_cpu;
            idx_nx = 8'h00;
            dly_nx = 3'd0;
            lat_nx = 2'd0;
            state_nx = START_STATE;
        end else if (!stall) begin
            case (state)
                DELAY: begin
                    dly_nx = dly_cnt == DLY_LAST ? 3'd0 : dly_cnt + 3'd1;
                    state_nx = dly_cnt == DLY_LAST ? READ : DELAY;
                end
                READ: begin
                    lat_nx = lat_cnt == LAT_LAST ? 2'd0 : lat_cnt + 2'd1;
                    data_nx = lat_cnt == LAT_LAST ? Di : data_q;
                    state_nx = lat_cnt == LAT_LAST ? WRITE : READ;
                end
                WRITE: begin
                    idx_nx = idx_inc[7:0];
                    state_nx = idx_inc == LAST_IDX ? IDLE : READ;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src_hi <= 8'h00;
            idx <= 8'h00;
            data_q <= 8'h00;
            dly_cnt <= 3'd0;
            lat_cnt <= 2'd0;
        end else begin
            state <= state_nx;
            src_hi <= src_hi_nx;
            idx <= idx_nx;
            data_q <= data_nx;
            dly_cnt <= dly_nx;
            lat_cnt <= lat_nx;
        end
    end
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: scoreboard bench for oam_dma_controller (default build and slow-read variant).
module tb_oam_dma_controller;
    logic clock, reset;
    logic [15:0] A_cpu, A, a2_cpu, a2;
    logic [7:0] Di_cpu, Do_cpu, Do, Di, di2_cpu, do2_cpu, do2, di2;
    logic rd_cpu_n, wr_cpu_n, rd_n, wr_n, dma_active;
    logic rd2_cpu_n, wr2_cpu_n, rd2_n, wr2_n, act2;
    logic [7:0] mem [0:65535];
    logic [23:0] q[$], q2[$];
    int errors = 0, checks = 0, act_cnt = 0, act2_cnt = 0, wr_cnt = 0, wr2_cnt = 0, fe_wr = 0;

    oam_dma_controller dut (
        .clock(clock), .reset(reset), .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu),
        .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n), .A(A), .Do(Do), .Di(Di),
        .rd_n(rd_n), .wr_n(wr_n), .dma_active(dma_active)
    );
    oam_dma_controller #(.RD_LATENCY(3), .START_DELAY(0)) dut2 (
        .clock(clock), .reset(reset), .A_cpu(a2_cpu), .Di_cpu(di2_cpu), .Do_cpu(do2_cpu),
        .rd_cpu_n(rd2_cpu_n), .wr_cpu_n(wr2_cpu_n), .A(a2), .Do(do2), .Di(di2),
        .rd_n(rd2_n), .wr_n(wr2_n), .dma_active(act2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    assign Di = mem[A];
    assign di2 = mem[a2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (dma_active) act_cnt++;
        if (!wr_n && A[15:8] == 8'hFE) begin
            fe_wr++;
            if (q.size() == 0) check("unexpected_oam_wr", {8'h00, A, Do}, 32'h0);
            else begin
                wr_cnt++;
                check("oam_wr", {8'h00, A, Do}, {8'h00, q.pop_front()});
            end
        end
    end

    always @(negedge clock) begin
        if (act2) act2_cnt++;
        if (!wr2_n && a2[15:8] == 8'hFE) begin
            if (q2.size() == 0) check("unexpected_oam_wr2", {8'h00, a2, do2}, 32'h0);
            else begin
                wr2_cnt++;
                check("oam_wr2", {8'h00, a2, do2}, {8'h00, q2.pop_front()});
            end
        end
    end

    task automatic start_dma(input logic [7:0] src);
        @(posedge clock); #1;
        A_cpu = 16'hFF46; Di_cpu = src; wr_cpu_n = 1'b0;
        @(posedge clock); #1;
        wr_cpu_n = 1'b1; A_cpu = 16'h0000;
        q.delete();
        for (int i = 0; i < 160; i++) q.push_back({16'hFE00 + 16'(i), mem[{src, 8'(i)}]});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dma_active && n < 3000) begin @(negedge clock); n++; end
        if (n >= 3000) check(tag, {31'd0, dma_active}, 32'd0);
    endtask

    task automatic wait_wr(input string tag, input logic [15:0] addr);
        int n = 0;
        do begin @(negedge clock); n++; end while (!(!wr_n && A == addr) && n < 3000);
        if (n >= 3000) check(tag, {15'd0, wr_n, A}, {16'd0, addr});
    endtask

    initial begin
        int hold, n, fe_before;
        for (int i = 0; i < 65536; i++) mem[i] = (8'(i) * 8'd37) ^ 8'(i >> 8) ^ 8'h5A;
        reset = 1'b1; A_cpu = 16'h1234; Di_cpu = 8'h00; rd_cpu_n = 1'b0; wr_cpu_n = 1'b1;
        a2_cpu = 16'h0000; di2_cpu = 8'h00; rd2_cpu_n = 1'b1; wr2_cpu_n = 1'b1;
        #2;
        check("rst_active", {31'd0, dma_active}, 32'd0);
        check("rst_pass_a", {16'd0, A}, 32'h1234);
        check("rst_pass_rdn", {31'd0, rd_n}, 32'd0);
        check("rst_pass_docpu", {24'd0, Do_cpu}, {24'd0, mem[16'h1234]});
        A_cpu = 16'hFF46; #1;
        check("rst_reg", {24'd0, Do_cpu}, 32'h00);
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        @(posedge clock); #1 reset = 1'b0;

        // basic transfer with busy-bus CPU reads
        act_cnt = 0; wr_cnt = 0;
        start_dma(8'h12);
        repeat (20) @(posedge clock);
        #1 A_cpu = 16'hC000; rd_cpu_n = 1'b0;
        @(negedge clock);
        check("busy_rd_data", {24'd0, Do_cpu}, 32'hFF);
        check("busy_rd_fwd", {31'd0, A == 16'hC000 && !rd_n}, 32'd0);
        #1 A_cpu = 16'hFF46; #1;
        check("busy_reg_rd", {24'd0, Do_cpu}, 32'h12);
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        wait_idle("t1_timeout");
        check("t1_cycles", act_cnt, 321);
        check("t1_writes", wr_cnt, 160);
        check("t1_queue", q.size(), 0);

        // restart at byte 50
        act_cnt = 0; wr_cnt = 0;
        start_dma(8'h12);
        wait_wr("t2_wait", 16'hFE31);
        start_dma(8'hC0);
        wait_idle("t2_timeout");
        check("t2_cycles", act_cnt, 423);
        check("t2_writes", wr_cnt, 210);
        check("t2_queue", q.size(), 0);

        // reset during the WRITE of byte 10
        start_dma(8'h12);
        wait_wr("t3_wait", 16'hFE0A);
        #1 reset = 1'b1; #1;
        check("t3_active", {31'd0, dma_active}, 32'd0);
        A_cpu = 16'h8000; wr_cpu_n = 1'b0; #1;
        check("t3_wrn", {31'd0, wr_n}, 32'd0);
        check("t3_addr", {16'd0, A}, 32'h8000);
        wr_cpu_n = 1'b1; A_cpu = 16'h0000;
        q.delete();
        fe_before = fe_wr;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        A_cpu = 16'hFF46; rd_cpu_n = 1'b0; #1;
        check("t3_reg", {24'd0, Do_cpu}, 32'h00);
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        repeat (30) @(negedge clock);
        check("t3_no_wr", fe_wr - fe_before, 0);
        check("t3_idle", {31'd0, dma_active}, 32'd0);

        // HRAM read at byte 5
        act_cnt = 0; wr_cnt = 0;
        start_dma(8'h12);
        wait_wr("t4_wait", 16'hFE05);
        @(posedge clock); #1 A_cpu = 16'hFF90; rd_cpu_n = 1'b0;
        @(negedge clock);
`ifdef OAM_DMA_HRAM_PASSTHRU_EN
        check("t4_addr", {16'd0, A}, 32'hFF90);
        check("t4_rdn", {31'd0, rd_n}, 32'd0);
        check("t4_docpu", {24'd0, Do_cpu}, {24'd0, mem[16'hFF90]});
`else
        check("t4_docpu", {24'd0, Do_cpu}, 32'hFF);
        check("t4_fwd", {31'd0, A == 16'hFF90}, 32'd0);
`endif
        @(posedge clock); #1 rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        wait_idle("t4_timeout");
`ifdef OAM_DMA_HRAM_PASSTHRU_EN
        check("t4_cycles", act_cnt, 322);
`else
        check("t4_cycles", act_cnt, 321);
`endif
        check("t4_writes", wr_cnt, 160);

        // RD_LATENCY=3, START_DELAY=0 instance
        act2_cnt = 0; wr2_cnt = 0;
        @(posedge clock); #1 a2_cpu = 16'hFF46; di2_cpu = 8'h80; wr2_cpu_n = 1'b0;
        @(posedge clock); #1 wr2_cpu_n = 1'b1; a2_cpu = 16'h0000;
        for (int i = 0; i < 160; i++) q2.push_back({16'hFE00 + 16'(i), mem[{8'h80, 8'(i)}]});
        @(negedge clock);
        check("t5_first_rd", {15'd0, rd2_n, a2}, 32'h8000);
        hold = 1;
        @(negedge clock);
        while (!rd2_n && hold < 8) begin hold++; @(negedge clock); end
        check("t5_rd_hold", hold, 3);
        n = 0;
        while (act2 && n < 3000) begin @(negedge clock); n++; end
        if (n >= 3000) check("t5_timeout", {31'd0, act2}, 32'd0);
        check("t5_cycles", act2_cnt, 640);
        check("t5_writes", wr2_cnt, 160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
